// File: rtl/pc_unit.sv
// Registered program counter for the single-cycle MIPS core: next-PC selection,
// stall hold, latched interrupts, EPC/ERET and misaligned-jr exception entry.
module pc_unit #(
    parameter logic [31:0] RESET_VEC   = 32'h0000_3000,
    parameter logic [31:0] EXC_VEC     = 32'h0000_4180,
    parameter bit          CHECK_ALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [2:0]  npc_sel,
    input  logic        zero,
    input  logic [31:0] rs_val,
    input  logic [31:0] imm32,
    input  logic        eret,
    input  logic        intreq,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] epc,
    output logic        in_handler,
    output logic        exc_taken,
    output logic        exc_cause
);

    typedef enum logic {
        RUN     = 1'b0,
        HANDLER = 1'b1
    } state_t;

    state_t             state;
    logic               int_pend;
    logic signed [31:0] br_off;
    logic [31:0]        br_tgt;
    logic [31:0]        seq_npc;
    logic               misalign;
    logic               take_exc;
    logic               take_int;
    logic               do_eret;
    logic               unused_imm_hi;

    // Word offset is sign-extended and scaled to bytes; it is relative to pc, not pc+4.
    function automatic logic signed [31:0] branch_offset(input logic [15:0] off);
        return {{14{off[15]}}, off, 2'b00};
    endfunction

    assign unused_imm_hi = ^imm32[31:26];
    assign pc_plus4      = pc + 32'd4;
    assign br_off        = branch_offset(imm32[15:0]);
    assign br_tgt        = pc + br_off;

    always_comb begin
        seq_npc = pc_plus4;
        case (npc_sel)
            3'b001:  seq_npc = zero  ? br_tgt : pc_plus4;
            3'b100:  seq_npc = !zero ? br_tgt : pc_plus4;
            3'b010:  seq_npc = {pc[31:28], imm32[25:0], 2'b00};
            3'b011:  seq_npc = rs_val;
            default: seq_npc = pc_plus4;
        endcase
    end

    assign misalign   = CHECK_ALIGN && (npc_sel == 3'b011) && (rs_val[1:0] != 2'b00);
    assign take_exc   = misalign && (state == RUN);
    assign take_int   = (int_pend || intreq) && (state == RUN) && !misalign;
    assign do_eret    = eret && (state == HANDLER);
    assign in_handler = (state == HANDLER);

    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RESET_VEC;
            epc       <= 32'd0;
            state     <= RUN;
            exc_taken <= 1'b0;
            exc_cause <= 1'b0;
            int_pend  <= 1'b0;
        end else begin
            exc_taken <= 1'b0;
            // The request latch keeps capturing pulses even while stalled or masked.
            if (intreq) begin
                int_pend <= 1'b1;
            end
            if (!stall) begin
                if (take_exc) begin
                    pc        <= EXC_VEC;
                    epc       <= pc;
                    exc_cause <= 1'b1;
                    state     <= HANDLER;
                    exc_taken <= 1'b1;
                end else if (take_int) begin
                    pc        <= EXC_VEC;
                    epc       <= seq_npc;
                    exc_cause <= 1'b0;
                    state     <= HANDLER;
                    exc_taken <= 1'b1;
                    int_pend  <= 1'b0;
                end else if (do_eret) begin
                    pc    <= epc;
                    state <= RUN;
                end else begin
                    pc <= seq_npc;
                end
            end
        end
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Registered program-counter unit for the single-cycle MIPS core. It is the parametrised successor of the combinational next-PC selector.
- Owns the PC register and computes next-PC for sequential, beq, bne, j/jal and jr flow.
- Adds stall hold, a latched interrupt request, an internal EPC, handler-mode masking, ERET return, and misaligned-jr exception detection.
- Sits between the controller/ALU outputs and instruction memory.

Parameters:
- RESET_VEC, 32'h0000_3000, PC value loaded on reset.
- EXC_VEC, 32'h0000_4180, handler entry address for interrupts and exceptions.
- CHECK_ALIGN, 1, when 1 a jr target with bits[1:0]!=0 raises an exception; when 0 such a target is taken as-is.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold PC and all state this cycle.
- npc_sel  in  3  000 seq, 001 beq, 010 j/jal, 011 jr, 100 bne; others treated as seq.
- zero  in  1  ALU equality flag.
- rs_val  in  32  GPR[rs], the jr target.
- imm32  in  32  current instruction word; [15:0] is the branch offset, [25:0] the jump index.
- eret  in  1  ERET instruction executing.
- intreq  in  1  external interrupt request; may be a single-cycle pulse.
- pc  out  32  current PC (register).
- pc_plus4  out  32  pc+4, combinational; used as the jal link value.
- epc  out  32  saved return address (register).
- in_handler  out  1  handler mode, interrupts masked (register).
- exc_taken  out  1  one-cycle pulse in the cycle after a vector is taken (register).
- exc_cause  out  1  0 = interrupt, 1 = misaligned jr; valid while in_handler (register).

Behaviour:
- Reset (rst=1 at a clk edge): pc=RESET_VEC, epc=0, in_handler=0, exc_taken=0, exc_cause=0, int_pend=0. Reset has priority over stall and every other input.
- Sequential target (seq_npc), combinational:
  - 000: pc+4.
  - 001: zero ? pc+(sext(imm32[15:0])<<2) : pc+4.
  - 100: !zero ? branch target : pc+4.
  - 010: {pc[31:28], imm32[25:0], 2'b00}.
  - 011: rs_val.
- All adds are 32-bit modulo with wrap-around; no overflow detection. The branch offset is relative to pc, not pc+4, as in the previous generation.
- int_pend: set on any edge where intreq=1. Cleared only when the interrupt is taken. It captures a pulse arriving during a stall or in handler mode.
- misalign: CHECK_ALIGN && npc_sel==011 && rs_val[1:0]!=0.
- Per edge, when !rst && !stall, priority order:
  1. misalign && !in_handler: pc<=EXC_VEC, epc<=pc (the faulting jr), exc_cause<=1, in_handler<=1, exc_taken<=1.
  2. (int_pend||intreq) && !in_handler: pc<=EXC_VEC, epc<=seq_npc (resume point), exc_cause<=0, in_handler<=1, exc_taken<=1, int_pend<=0.
  3. eret && in_handler: pc<=epc, in_handler<=0. A pending interrupt is not taken this edge; it is taken on the next unstalled edge.
  4. Otherwise: pc<=seq_npc. An eret with in_handler=0 is ignored and treated as seq_npc.
- exc_taken is 0 on every edge where rule 1 or 2 did not fire, including stalled edges.
- misalign while in_handler: no nesting; pc<=rs_val unchanged.
- Stall: pc, epc, in_handler and exc_cause hold. exc_taken<=0. int_pend may still set.
- Reset mid-handler: fully clears state; the pending interrupt is discarded.
- State machine: two states, RUN (in_handler=0) and HANDLER (in_handler=1).
  - RUN -> HANDLER on rule 1 or 2.
  - HANDLER -> RUN on rule 3.
- Latency: each redirect is visible on pc one clock after the deciding edge's inputs.

Test Plan:
- Reset release, npc_sel=000, 3 edges -> pc = 3000, 3004, 3008, 300C; pc_plus4 = pc+4.
- At pc=3010, npc_sel=001, zero=1, imm32[15:0]=FFFC -> pc=3000. Same stimulus with zero=0 -> 3014. npc_sel=100, zero=0 -> 3000.
- At pc=3000, npc_sel=010, imm32=0x0000_0C10 -> pc=3040. npc_sel=011, rs_val=0x3100 -> pc=3100.
- One-cycle intreq pulse during stall=1 at pc=3008, npc_sel=000, then stall=0:
  - On the unstalled edge -> pc=4180, epc=300C, in_handler=1, exc_cause=0.
  - exc_taken=1 in the cycle after that edge, then 0.
- In handler, intreq=1 and eret=1 together:
  - First edge -> pc=300C, in_handler=0.
  - Next edge -> pc=4180, epc = seq_npc of 300C.
- npc_sel=011, rs_val=0x3102, pc=3020, CHECK_ALIGN=1 -> pc=4180, epc=3020, exc_cause=1. With CHECK_ALIGN=0 -> pc=3102.
